// File: rtl/uop_stage_fifo_if.sv
// Valid/ready handshake bundle for uop_stage_fifo: producer side, consumer side,
// pipeline flush and occupancy.
interface uop_stage_fifo_if #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic             flush;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic [CW-1:0]    count;

    // master drives the stage traffic, slave is the buffer itself
    modport master (output flush, inValid, inData, outReady,
                    input  inReady, outValid, outData, count);
    modport slave  (input  flush, inValid, inData, outReady,
                    output inReady, outValid, outData, count);
endinterface

// File: rtl/uop_stage_fifo.sv
// DEPTH-entry valid/ready decoupling buffer between core pipeline stages, with flush.
// Optional zero-latency bypass when empty: define UOP_FIFO_BYPASS_EN.
module uop_stage_fifo #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             rstN,
    uop_stage_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uop_stage_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             not_full;
    logic             not_empty;
    logic             in_ready;
    logic             push;
    logic             pop;

    assign not_full  = (cnt != CW'(DEPTH));
    assign not_empty = (cnt != '0);
    // inReady looks only at occupancy and flush, never at outReady
    assign in_ready    = not_full & ~bus.flush;
    assign bus.inReady = in_ready;
    assign bus.count   = cnt;

`ifdef UOP_FIFO_BYPASS_EN
    logic bypass;
    logic bypass_take;

    // An empty buffer forwards the incoming uop; it is stored only if not taken.
    assign bypass       = ~not_empty & bus.inValid & ~bus.flush;
    assign bypass_take  = bypass & bus.outReady;
    assign bus.outValid = (not_empty & ~bus.flush) | bypass;
    assign bus.outData  = bypass ? bus.inData : mem[rd_ptr];
    assign push         = bus.inValid & in_ready & ~bypass_take;
    assign pop          = not_empty & ~bus.flush & bus.outReady;
`else
    assign bus.outValid = not_empty & ~bus.flush;
    assign bus.outData  = mem[rd_ptr];
    assign push         = bus.inValid & in_ready;
    assign pop          = not_empty & ~bus.flush & bus.outReady;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; outData is only meaningful with outValid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.inData;
    end
endmodule

// File: tb/tb_uop_stage_fifo.sv
// Self-checking bench for uop_stage_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours UOP_FIFO_BYPASS_EN.
module tb_uop_stage_fifo;
  localparam int WIDTH = 62;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UOP_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  uop_stage_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  uop_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rstN(rstN), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] q[$];
  logic             exp_in_ready;
  logic             exp_out_valid;
  logic             exp_bypass;
  logic [WIDTH-1:0] exp_out_data;
  int               exp_count;

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    bus.inValid  = v;
    bus.inData   = d;
    bus.outReady = r;
    bus.flush    = f;
  endtask

  // reference: a queue of accepted uops, outputs derived from its length
  task automatic model_eval();
    exp_count     = q.size();
    exp_in_ready  = (q.size() < DEPTH) && !bus.flush;
    exp_bypass    = BYP && (q.size() == 0) && bus.inValid && !bus.flush;
    exp_out_valid = ((q.size() > 0) && !bus.flush) || exp_bypass;
    exp_out_data  = exp_bypass ? bus.inData : ((q.size() > 0) ? q[0] : '0);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (bus.flush) q.delete();
    else if (!(exp_bypass && bus.outReady)) begin
      if (exp_out_valid && bus.outReady) q.delete(0);
      if (bus.inValid && exp_in_ready) q.push_back(bus.inData);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outValid: got %b expected 0", bus.outValid); end
    n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL reset_inReady: got %b expected 1", bus.inReady); end
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL prereset_count: got %0d expected 3", bus.count); end
    #1 rstN = 1'b0;
    #1 q.delete();
    n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL midreset_outValid: got %b expected 0", bus.outValid); end
    n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL midreset_inReady: got %b expected 1", bus.inReady); end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, WIDTH'(8'hA1 + i), 1'b0, 1'b0);
      #1;
      n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL fill_inReady[%0d]: got %b expected 1", i, bus.inReady); end
      n_checks++; if (bus.count !== CW'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, i); end
      tick();
    end
    drive(1'b1, WIDTH'(8'hA5), 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(4)) begin n_fail++; $display("FAIL full_count: got %0d expected 4", bus.count); end
    n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL full_inReady: got %b expected 0", bus.inReady); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(4)) begin n_fail++; $display("FAIL refused_count: got %0d expected 4", bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      #1;
      n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL drain_outValid[%0d]: got %b expected 1", i, bus.outValid); end
      n_checks++; if (bus.outData !== WIDTH'(8'hA1 + i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, bus.outData, WIDTH'(8'hA1 + i)); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL drained_outValid: got %b expected 0", bus.outValid); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, WIDTH'(8'hB1 + i), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, WIDTH'(12'hB50 + i), 1'b1, 1'b0);
      #1 model_eval();
      n_checks++; if (bus.count !== CW'(2)) begin n_fail++; $display("FAIL simul_count[%0d]: got %0d expected 2", i, bus.count); end
      n_checks++; if (bus.outData !== exp_out_data) begin n_fail++; $display("FAIL simul_data[%0d]: got %h expected %h", i, bus.outData, exp_out_data); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      #1;
      n_checks++; if (bus.outData !== WIDTH'(12'hB56 + i)) begin n_fail++; $display("FAIL simul_tail[%0d]: got %h expected %h", i, bus.outData, WIDTH'(12'hB56 + i)); end
      tick();
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, WIDTH'(8'hD0 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, WIDTH'(8'hDD), 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL fullpop_inReady: got %b expected 0", bus.inReady); end
    n_checks++; if (bus.outData !== WIDTH'(8'hD0)) begin n_fail++; $display("FAIL fullpop_data: got %h expected d0", bus.outData); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 3", bus.count); end
    n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL fullpop_inReady_next: got %b expected 1", bus.inReady); end
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      #1;
      n_checks++; if (bus.outData !== WIDTH'(8'hD0 + i)) begin n_fail++; $display("FAIL fullpop_drain[%0d]: got %h expected %h", i, bus.outData, WIDTH'(8'hD0 + i)); end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(8'hE0 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, WIDTH'(8'hEE), 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL flush_inReady: got %b expected 0", bus.inReady); end
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL flush_outValid: got %b expected 0", bus.outValid); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL postflush_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL postflush_outValid: got %b expected 0", bus.outValid); end
    drive(1'b1, WIDTH'(8'hF0), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.outData !== WIDTH'(8'hF0)) begin n_fail++; $display("FAIL postflush_data: got %h expected f0", bus.outData); end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, WIDTH'(8'hC7), 1'b1, 1'b0);
    #1;
`ifdef UOP_FIFO_BYPASS_EN
    n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL bypass_outValid: got %b expected 1", bus.outValid); end
    n_checks++; if (bus.outData !== WIDTH'(8'hC7)) begin n_fail++; $display("FAIL bypass_data: got %h expected c7", bus.outData); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", bus.count); end
    drive(1'b1, WIDTH'(8'hC8), 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.outData !== WIDTH'(8'hC8)) begin n_fail++; $display("FAIL bypass_stall_data: got %h expected c8", bus.outData); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL bypass_stall_count: got %0d expected 1", bus.count); end
    tick();
`else
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL nobypass_outValid: got %b expected 0", bus.outValid); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL nobypass_count: got %0d expected 1", bus.count); end
    n_checks++; if (bus.outData !== WIDTH'(8'hC7)) begin n_fail++; $display("FAIL nobypass_data: got %h expected c7", bus.outData); end
    tick();
`endif
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 400; i++) begin
      d = WIDTH'({$urandom(), $urandom()});
      drive(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      #1 model_eval();
      n_checks++; if (bus.count !== CW'(exp_count)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, bus.count, exp_count); end
      n_checks++; if (bus.inReady !== exp_in_ready) begin n_fail++; $display("FAIL rand_inReady[%0d]: got %b expected %b", i, bus.inReady, exp_in_ready); end
      n_checks++; if (bus.outValid !== exp_out_valid) begin n_fail++; $display("FAIL rand_outValid[%0d]: got %b expected %b", i, bus.outValid, exp_out_valid); end
      if (exp_out_valid) begin
        n_checks++; if (bus.outData !== exp_out_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, bus.outData, exp_out_data); end
      end
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_full_pop();
    test_flush();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
